// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern driver: display mode encodings and widths.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STEADY    = 2'b00,
    MODE_DIM       = 2'b01,
    MODE_BLINK     = 2'b10,
    MODE_BLINK_DIM = 2'b11
  } mode_t;

  localparam int LED_WIDTH   = 14;
  localparam int COUNT_WIDTH = 8;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM generator; a new duty is latched only at the end of a period
// so the on-count never changes mid-period.
module led_pwm_gen
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) begin
        duty_q <= duty;
      end
    end
  end

  // duty_q of 0 keeps the output dark for the whole period
  assign pwm_on = (pwm_cnt < duty_q);

endmodule

// File: rtl/led_pattern_driver.sv
// Drives the LED pins from the PIO pattern, gated by steady/dim/blink modes,
// and reports pattern changes as a pulse plus a saturating debug counter.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int WIDTH     = LED_WIDTH,
  parameter int PWM_BITS  = 8,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       pattern,
  input  logic [1:0]             mode,
  input  logic [PWM_BITS-1:0]    duty,
  input  logic                   count_clr,
  output logic [WIDTH-1:0]       led_out,
  output logic                   change_pulse,
  output logic [COUNT_WIDTH-1:0] change_count
);

  localparam int BLINK_BITS = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_BITS-1:0] BLINK_LAST = BLINK_BITS'(BLINK_DIV - 1);

  logic [WIDTH-1:0]      pattern_q;
  logic [WIDTH-1:0]      pattern_prev;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  blink_phase;
  logic                  pwm_on;
  logic                  gate;
  logic                  changed;

  led_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk   (clk),
    .reset (reset),
    .duty  (duty),
    .pwm_on(pwm_on)
  );

  // Blink prescaler: phase 0 is dark, so blinking starts dark after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    gate = 1'b1;
    case (mode_t'(mode))
      MODE_STEADY:    gate = 1'b1;
      MODE_DIM:       gate = pwm_on;
      MODE_BLINK:     gate = blink_phase;
      MODE_BLINK_DIM: gate = blink_phase & pwm_on;
      default:        gate = 1'b1;
    endcase
  end

  assign changed = (pattern_q != pattern_prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q    <= '0;
      pattern_prev <= '0;
      led_out      <= '0;
      change_pulse <= 1'b0;
    end else begin
      pattern_q    <= pattern;
      pattern_prev <= pattern_q;
      led_out      <= pattern_q & {WIDTH{gate}};
      change_pulse <= changed;
    end
  end

  // Clear takes priority over a coincident change; the count sticks at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      change_count <= '0;
    end else if (count_clr) begin
      change_count <= '0;
    end else if (changed && (change_count != '1)) begin
      change_count <= change_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Randomised and directed bench for led_pattern_driver, checked every cycle
// against a count-based behavioural model plus a few hand-computed expectations.
module tb_led_pattern_driver;

  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] pattern = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  duty = '0;
  logic        count_clr = 1'b0;
  logic [13:0] led_out;
  logic        change_pulse;
  logic [7:0]  change_count;

  int checks = 0;
  int passes = 0;

  led_pattern_driver #(
    .WIDTH    (14),
    .PWM_BITS (8),
    .BLINK_DIV(BD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pattern     (pattern),
    .mode        (mode),
    .duty        (duty),
    .count_clr   (count_clr),
    .led_out     (led_out),
    .change_pulse(change_pulse),
    .change_count(change_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic r, input logic [13:0] p, input logic [1:0] m,
                               input logic [7:0] d, input logic c);
    @(negedge clk);
    reset = r; pattern = p; mode = m; duty = d; count_clr = c;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count samples with a lit LED over n cycles, sampled just after each edge
  task automatic countLit(input int n, output int lit);
    lit = 0;
    repeat (n) begin
      @(posedge clk);
      #2;
      if (led_out != '0) lit++;
    end
  endtask

  // Model: n counts edges since reset, so PWM position, blink phase and
  // period boundaries come straight from arithmetic on n.
  int          n = 0;
  int          dq = 0;
  logic [13:0] q1 = '0, q2 = '0;
  int          ecnt = 0;
  logic [13:0] eled = '0;
  logic        epulse = 1'b0;
  bit          started = 1'b0;

  initial begin
    forever begin
      logic        r, c, g, pon, ph;
      logic [13:0] p;
      logic [1:0]  m;
      int          d, pc;
      @(posedge clk);
      r = reset; p = pattern; m = mode; d = int'(duty); c = count_clr;
      if (r) begin
        n = 0; dq = 0; q1 = '0; q2 = '0; ecnt = 0;
        eled = '0; epulse = 1'b0; started = 1'b1;
      end else begin
        pc  = n % 256;
        ph  = ((n / BD) % 2) == 1;
        pon = pc < dq;
        case (m)
          2'd0: g = 1'b1;
          2'd1: g = pon;
          2'd2: g = ph;
          default: g = ph & pon;
        endcase
        eled   = g ? q1 : 14'h0;
        epulse = (q1 != q2);
        if (c) ecnt = 0;
        else if (epulse && ecnt < 255) ecnt = ecnt + 1;
        if (pc == 255) dq = d;
        q2 = q1; q1 = p; n++;
      end
      #1;
      if (started) begin
        checkOutput("led_out", 32'(led_out), 32'(eled));
        checkOutput("change_pulse", 32'(change_pulse), 32'(epulse));
        checkOutput("change_count", 32'(change_count), 32'(ecnt));
      end
    end
  end

  initial begin
    int lit;
    logic [15:0] blink_bits;
    logic [13:0] tp;

    // Reset held with a full pattern, then released in steady mode
    applyStimulus(1, 14'h3FFF, 2'd0, 8'd0, 0);
    waitCycles(3);
    checkOutput("reset_led", 32'(led_out), 32'h0);
    checkOutput("reset_count", 32'(change_count), 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("release_led", 32'(led_out), 32'h3FFF);
    checkOutput("release_pulse", 32'(change_pulse), 32'h1);
    checkOutput("release_count", 32'(change_count), 32'h1);
    @(posedge clk);
    #2;
    checkOutput("release_pulse_once", 32'(change_pulse), 32'h0);

    // Steady latency: 3FFF->0 then 0->2A55
    applyStimulus(0, 14'h0000, 2'd0, 8'd0, 0);
    waitCycles(5);
    applyStimulus(0, 14'h2A55, 2'd0, 8'd0, 0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("steady_led", 32'(led_out), 32'h2A55);
    checkOutput("steady_pulse", 32'(change_pulse), 32'h1);
    checkOutput("steady_count", 32'(change_count), 32'h3);

    // DIM with duty 64, then 192 applied mid-period
    applyStimulus(0, 14'h2A55, 2'd1, 8'd64, 0);
    waitCycles(300);
    countLit(512, lit);
    checkOutput("dim64_lit", 32'(lit), 32'd128);
    applyStimulus(0, 14'h2A55, 2'd1, 8'd192, 0);
    waitCycles(300);
    countLit(256, lit);
    checkOutput("dim192_lit", 32'(lit), 32'd192);

    // BLINK from reset: dark 4, lit 4, alternating
    applyStimulus(1, 14'h1234, 2'd2, 8'd192, 0);
    applyStimulus(0, 14'h1234, 2'd2, 8'd192, 0);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #2;
      blink_bits[k] = (led_out != '0);
    end
    checkOutput("blink_seq", 32'(blink_bits), 32'h0000F0F0);
    applyStimulus(0, 14'h1234, 2'd3, 8'd128, 0);
    waitCycles(600);

    // Saturation after 300 alternating changes, then clear against a pulse
    for (int i = 0; i < 300; i++)
      applyStimulus(0, i[0] ? 14'h0F0F : 14'h30F0, 2'd0, 8'd128, 0);
    waitCycles(3);
    checkOutput("count_saturated", 32'(change_count), 32'd255);
    applyStimulus(0, 14'h1111, 2'd0, 8'd128, 0);
    applyStimulus(0, 14'h1111, 2'd0, 8'd128, 1);
    @(posedge clk);
    #2;
    checkOutput("clr_pulse", 32'(change_pulse), 32'h1);
    checkOutput("clr_count", 32'(change_count), 32'h0);
    applyStimulus(0, 14'h1111, 2'd0, 8'd128, 0);

    // Reset in the middle of BLINK_DIM activity
    for (int i = 0; i < 5; i++)
      applyStimulus(0, i[0] ? 14'h2222 : 14'h0444, 2'd3, 8'd128, 0);
    waitCycles(100);
    applyStimulus(1, 14'h2222, 2'd3, 8'd128, 0);
    @(posedge clk);
    #2;
    checkOutput("midreset_led", 32'(led_out), 32'h0);
    checkOutput("midreset_count", 32'(change_count), 32'h0);
    applyStimulus(0, 14'h2222, 2'd1, 8'd255, 0);
    countLit(256, lit);
    checkOutput("dim_dark_after_reset", 32'(lit), 32'd0);

    // Randomised traffic, model checked every cycle
    tp = 14'h2222;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) tp = 14'($urandom);
      @(negedge clk);
      pattern   = tp;
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 127) == 0) duty = 8'($urandom);
      count_clr = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 499) == 0);
    end
    applyStimulus(0, tp, mode, duty, 0);
    waitCycles(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
